riscv_muldiv: RTL and testbench
===============================

Name: riscv_muldiv

Overview:
- Iterative RV32M multiply/divide unit alongside the single-cycle ALU in the execute stage.
- Acts as responder to execute-stage requests.
- Operands and the operation are accepted via a valid/ready request handshake; the result is returned via a valid/ready response handshake.
- Shift-add multiply and restoring divide, one bit per cycle; divide special cases resolve in one cycle.

Parameters:
- XLEN, 32, operand/result width.
- CNT_W, 6, iteration counter width; must satisfy 2^CNT_W > XLEN.

Ports:
- clk  input  1  clock; all state updates on the rising edge.
- rst_n  input  1  asynchronous active-low reset.
- in_valid  input  1  request valid.
- in_ready  output  1  unit can accept a request.
- op  input  3  000 MUL, 001 MULH, 010 MULHSU, 011 MULHU, 100 DIV, 101 DIVU, 110 REM, 111 REMU.
- a  input  XLEN  rs1 operand.
- b  input  XLEN  rs2 operand.
- flush  input  1  pipeline kill; aborts any in-flight operation.
- out_valid  output  1  result valid.
- out_ready  input  1  consumer accepts the result.
- result  output  XLEN  operation result.
- busy  output  1  high in CALC or DONE.

Behaviour:
- States: IDLE, CALC, DONE.
- Reset, asynchronous: state=IDLE, in_ready=1, out_valid=0, busy=0, result=0, counter=0, internal registers=0.
- IDLE:
  - in_ready=1.
  - When in_valid=1 at an edge, latch op, a and b, and apply sign handling:
    - DIV/REM: operate on absolute values; record the quotient sign (a[31]^b[31]) and the remainder sign (a[31]).
    - MULH: both operands signed.
    - MULHSU: a signed, b unsigned.
    - MULHU/MUL: both unsigned; MUL returns the low 32 bits of the product, which is sign-independent.
- Division special cases, detected at accept; go directly to DONE, so out_valid is high after one edge:
  - Divide by zero (b==0): DIV/DIVU quotient=0xFFFFFFFF; REM/REMU remainder=a.
  - Signed overflow (a==0x80000000, b==0xFFFFFFFF, DIV/REM only): quotient=0x80000000, remainder=0.
- Otherwise go to CALC with counter=0.
- CALC:
  - One iteration per cycle, counter increments.
  - Multiply: 64-bit accumulator, add the shifted multiplicand when the current multiplier bit is 1.
  - Divide: restoring, shift the remainder left, trial subtract, set the quotient bit.
  - After the iteration with counter==XLEN-1, go to DONE.
  - Accepted at edge N, out_valid is first high after edge N+32.
- DONE:
  - Apply the final sign correction: negate the product for signed MULH/MULHSU when the signs differ; negate the quotient and remainder per the recorded signs.
  - Select the high or low half, quotient or remainder; result is registered.
  - out_valid=1; result holds stable until out_ready=1 at an edge, then go to IDLE.
  - No accept is possible in the handshake cycle; in_ready rises the following cycle.
- out_ready may be high before out_valid; this has no effect outside DONE.
- flush=1 at an edge in any state: go to IDLE, out_valid=0, and discard the operation.
  - flush overrides a simultaneous in_valid accept and a simultaneous out_ready handshake.
- Inputs a, b and op are don't-care outside the accept cycle; changing them mid-CALC has no effect.
- Reset mid-CALC: immediate return to the reset state, no output glitch to valid.
- All arithmetic is modulo 2^XLEN; negating 0x80000000 yields 0x80000000.

Optional Feature:
- MULDIV_FAST_MUL_EN defined:
  - Multiply ops (op[2]==0) compute the full 64-bit product combinationally at accept and go directly to DONE.
  - out_valid is high after one edge.
  - Divide behaviour is unchanged.
- Undefined: all multiplies use the 32-cycle iterative path; no hardware multiplier is inferred.

Test Plan:
- MUL: a=10, b=20 -> after 32 cycles out_valid=1, result=200; busy=1 throughout.
- MULH: a=0xFFFFFFFF (-1), b=0x00000002 -> result=0xFFFFFFFF. MULHU with the same operands -> result=0x00000001.
- DIV: a=-20 (0xFFFFFFEC), b=3 -> result=0xFFFFFFFA (-6). REM with the same operands -> result=0xFFFFFFFE (-2). DIVU: a=100, b=7 -> result=14.
- DIVU: a=5, b=0 -> out_valid after 1 edge, result=0xFFFFFFFF. REM: a=5, b=0 -> result=5. DIV: a=0x80000000, b=0xFFFFFFFF -> result=0x80000000 after 1 edge.
- Back-pressure and flush:
  - Hold out_ready=0 for 5 cycles in DONE -> result stable and in_ready=0; then out_ready=1 -> IDLE next cycle.
  - Assert flush at cycle 10 of CALC -> out_valid never rises, in_ready=1 next cycle.
- Async reset: drop rst_n mid-CALC between clock edges -> outputs go to reset values immediately. A new MUL of 3×4 after release -> result=12.

Source files
------------

// File: rtl/riscv_muldiv.sv
// Iterative RV32M multiply/divide unit: shift-add multiply, restoring divide, one bit per cycle.
// Define MULDIV_FAST_MUL_EN to resolve multiplies in one cycle with a combinational multiplier.
module riscv_muldiv #(
   parameter int XLEN  = 32,
   parameter int CNT_W = 6
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [2:0]      op,
   input  logic [XLEN-1:0] a,
   input  logic [XLEN-1:0] b,
   input  logic            flush,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            busy
);

   typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

   localparam logic [XLEN-1:0]  MIN_INT = {1'b1, {(XLEN-1){1'b0}}};
   localparam logic [CNT_W-1:0] LAST    = CNT_W'(XLEN - 1);

   state_t            state;
   logic [2:0]        op_r;
   logic              neg_q, neg_r;
   logic [CNT_W-1:0]  cnt;
   logic [2*XLEN-1:0] acc, acc_step, prod_fix;
   logic [XLEN-1:0]   opb, quot_fix, rem_fix, final_res, special_res;
   logic [XLEN-1:0]   mag_a, mag_b;
   logic [XLEN:0]     mul_sum, trial, diff;
   logic              signed_a, signed_b, a_neg, b_neg, div_by_zero, div_ovf;

   // Operands are reduced to magnitudes at accept; signs are reapplied when the result is formed.
   assign signed_a    = (op == 3'b001) || (op == 3'b010) || (op[2] && !op[0]);
   assign signed_b    = (op == 3'b001) || (op[2] && !op[0]);
   assign a_neg       = signed_a & a[XLEN-1];
   assign b_neg       = signed_b & b[XLEN-1];
   assign mag_a       = a_neg ? -a : a;
   assign mag_b       = b_neg ? -b : b;
   assign div_by_zero = op[2] && (b == '0);
   assign div_ovf     = op[2] && !op[0] && (a == MIN_INT) && (b == '1);

   always_comb begin
      special_res = '0;
      if (div_by_zero) special_res = op[1] ? a : '1;
      else             special_res = op[1] ? '0 : MIN_INT;
   end

`ifdef MULDIV_FAST_MUL_EN
   logic [2*XLEN-1:0] fast_a, fast_b, fast_prod;
   logic [XLEN-1:0]   fast_res;
   assign fast_a    = {{XLEN{a_neg}}, a};
   assign fast_b    = {{XLEN{b_neg}}, b};
   assign fast_prod = fast_a * fast_b;
   assign fast_res  = (op == 3'b000) ? fast_prod[XLEN-1:0] : fast_prod[2*XLEN-1:XLEN];
`endif

   // acc holds {partial product, multiplier} for multiply and {remainder, dividend/quotient} for divide.
   always_comb begin
      mul_sum = {1'b0, acc[2*XLEN-1:XLEN]} + {1'b0, (acc[0] ? opb : '0)};
      trial   = {acc[2*XLEN-1:XLEN], acc[XLEN-1]};
      diff    = trial - {1'b0, opb};
      if (!op_r[2])          acc_step = {mul_sum, acc[XLEN-1:1]};
      else if (!diff[XLEN])  acc_step = {diff[XLEN-1:0], acc[XLEN-2:0], 1'b1};
      else                   acc_step = {trial[XLEN-1:0], acc[XLEN-2:0], 1'b0};
   end

   always_comb begin
      prod_fix  = neg_q ? -acc_step : acc_step;
      quot_fix  = neg_q ? -acc_step[XLEN-1:0] : acc_step[XLEN-1:0];
      rem_fix   = neg_r ? -acc_step[2*XLEN-1:XLEN] : acc_step[2*XLEN-1:XLEN];
      final_res = '0;
      case (op_r)
         3'b000:                 final_res = acc_step[XLEN-1:0];
         3'b001, 3'b010, 3'b011: final_res = prod_fix[2*XLEN-1:XLEN];
         3'b100, 3'b101:         final_res = quot_fix;
         default:                final_res = rem_fix;
      endcase
   end

   // Flush outranks both a new accept and a result handshake.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
         result    <= '0;
         cnt       <= '0;
         op_r      <= '0;
         neg_q     <= 1'b0;
         neg_r     <= 1'b0;
         acc       <= '0;
         opb       <= '0;
      end else if (flush) begin
         state     <= IDLE;
         in_ready  <= 1'b1;
         out_valid <= 1'b0;
         busy      <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (in_valid) begin
                  op_r     <= op;
                  neg_q    <= a_neg ^ b_neg;
                  neg_r    <= a_neg;
                  opb      <= mag_b;
                  acc      <= {{XLEN{1'b0}}, mag_a};
                  cnt      <= '0;
                  in_ready <= 1'b0;
                  busy     <= 1'b1;
                  if (div_by_zero || div_ovf) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     result    <= special_res;
                  end
`ifdef MULDIV_FAST_MUL_EN
                  else if (!op[2]) begin
                     state     <= DONE;
                     out_valid <= 1'b1;
                     result    <= fast_res;
                  end
`endif
                  else begin
                     state <= CALC;
                  end
               end
            end
            CALC: begin
               acc <= acc_step;
               cnt <= cnt + 1'b1;
               if (cnt == LAST) begin
                  state     <= DONE;
                  out_valid <= 1'b1;
                  result    <= final_res;
               end
            end
            DONE: begin
               if (out_ready) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
                  busy      <= 1'b0;
                  in_ready  <= 1'b1;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_riscv_muldiv.sv
// Directed self-checking bench for riscv_muldiv; expected values are hand-computed RV32M results.
// Multiply latency expectations follow MULDIV_FAST_MUL_EN when the bench is built with it.
module tb_riscv_muldiv;

   logic        clk, rst_n, in_valid, in_ready, flush, out_valid, out_ready, busy;
   logic [2:0]  op;
   logic [31:0] a, b, result;
   int          tests = 0;
   int          fails = 0;

`ifdef MULDIV_FAST_MUL_EN
   localparam int MUL_CYC = 0;
`else
   localparam int MUL_CYC = 32;
`endif

   riscv_muldiv dut (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
      .op(op), .a(a), .b(b), .flush(flush), .out_valid(out_valid),
      .out_ready(out_ready), .result(result), .busy(busy)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Drives one request for a single edge, then scrambles the operands.
   task automatic do_accept(input logic [2:0] o, input logic [31:0] x, input logic [31:0] y);
      @(negedge clk);
      in_valid = 1'b1; op = o; a = x; b = y;
      @(posedge clk); #1;
      in_valid = 1'b0; a = 32'hDEAD_BEEF; b = 32'h1234_5678; op = 3'b110;
   endtask

   task automatic wait_valid(output int cyc, output bit busy_ok);
      cyc = 0;
      busy_ok = 1'b1;
      while (!out_valid && cyc < 100) begin
         if (!busy) busy_ok = 1'b0;
         @(posedge clk); #1;
         cyc++;
      end
   endtask

   task automatic do_handshake();
      @(negedge clk);
      out_ready = 1'b1;
      @(posedge clk); #1;
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL reset in_ready: got %b expected 1", in_ready); end
      tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL reset out_valid: got %b expected 0", out_valid); end
      tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL reset busy: got %b expected 0", busy); end
      tests++; if (result !== 32'h0) begin fails++; $display("[TB] FAIL reset result: got %h expected 0", result); end
      @(negedge clk);
      rst_n = 1'b1;
   endtask

   task automatic test_mul();
      logic [2:0]  ops[6]  = '{3'b000, 3'b001, 3'b011, 3'b010, 3'b000, 3'b001};
      logic [31:0] va[6]   = '{32'd10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h8000_0000};
      logic [31:0] vb[6]   = '{32'd20, 32'd2, 32'd2, 32'd2, 32'hFFFF_FFFF, 32'h8000_0000};
      logic [31:0] exp[6]  = '{32'd200, 32'hFFFF_FFFF, 32'h1, 32'hFFFF_FFFF, 32'h1, 32'h4000_0000};
      int cyc;
      bit busy_ok;
      for (int i = 0; i < 6; i++) begin
         do_accept(ops[i], va[i], vb[i]);
         wait_valid(cyc, busy_ok);
         tests++; if (cyc != MUL_CYC) begin fails++; $display("[TB] FAIL mul[%0d] latency: got %0d expected %0d", i, cyc, MUL_CYC); end
         tests++; if (result !== exp[i]) begin fails++; $display("[TB] FAIL mul[%0d] result: got %h expected %h", i, result, exp[i]); end
         if (i == 0) begin
            tests++; if (!busy_ok || busy !== 1'b1) begin fails++; $display("[TB] FAIL mul busy: got %b expected 1", busy_ok & busy); end
         end
         do_handshake();
      end
   endtask

   task automatic test_div();
      logic [2:0]  ops[7]  = '{3'b100, 3'b110, 3'b101, 3'b111, 3'b100, 3'b110, 3'b101};
      logic [31:0] va[7]   = '{32'hFFFF_FFEC, 32'hFFFF_FFEC, 32'd100, 32'd100, 32'd20, 32'd20, 32'h8000_0000};
      logic [31:0] vb[7]   = '{32'd3, 32'd3, 32'd7, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFFD, 32'hFFFF_FFFF};
      logic [31:0] exp[7]  = '{32'hFFFF_FFFA, 32'hFFFF_FFFE, 32'd14, 32'd2, 32'hFFFF_FFFA, 32'd2, 32'd0};
      int cyc;
      bit busy_ok;
      for (int i = 0; i < 7; i++) begin
         do_accept(ops[i], va[i], vb[i]);
         wait_valid(cyc, busy_ok);
         tests++; if (cyc != 32) begin fails++; $display("[TB] FAIL div[%0d] latency: got %0d expected 32", i, cyc); end
         tests++; if (result !== exp[i]) begin fails++; $display("[TB] FAIL div[%0d] result: got %h expected %h", i, result, exp[i]); end
         do_handshake();
      end
   endtask

   task automatic test_special();
      logic [2:0]  ops[6]  = '{3'b101, 3'b110, 3'b100, 3'b110, 3'b100, 3'b111};
      logic [31:0] va[6]   = '{32'd5, 32'd5, 32'h8000_0000, 32'h8000_0000, 32'd5, 32'h8000_0000};
      logic [31:0] vb[6]   = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'd0, 32'd0};
      logic [31:0] exp[6]  = '{32'hFFFF_FFFF, 32'd5, 32'h8000_0000, 32'd0, 32'hFFFF_FFFF, 32'h8000_0000};
      int cyc;
      bit busy_ok;
      for (int i = 0; i < 6; i++) begin
         do_accept(ops[i], va[i], vb[i]);
         wait_valid(cyc, busy_ok);
         tests++; if (cyc != 0) begin fails++; $display("[TB] FAIL special[%0d] latency: got %0d expected 0", i, cyc); end
         tests++; if (result !== exp[i]) begin fails++; $display("[TB] FAIL special[%0d] result: got %h expected %h", i, result, exp[i]); end
         do_handshake();
      end
   endtask

   task automatic test_input_hold();
      int cyc;
      bit busy_ok;
      do_accept(3'b101, 32'd1000, 32'd9);
      repeat (5) @(posedge clk);
      #1;
      a = 32'd7; b = 32'd1; op = 3'b000;
      wait_valid(cyc, busy_ok);
      tests++; if (result !== 32'd111) begin fails++; $display("[TB] FAIL input_hold result: got %h expected %h", result, 32'd111); end
      do_handshake();
   endtask

   task automatic test_backpressure();
      int cyc;
      bit busy_ok;
      bit stable;
      do_accept(3'b000, 32'd7, 32'd6);
      wait_valid(cyc, busy_ok);
      stable = 1'b1;
      for (int i = 0; i < 5; i++) begin
         if (result !== 32'd42 || in_ready !== 1'b0 || out_valid !== 1'b1) stable = 1'b0;
         @(posedge clk); #1;
      end
      tests++; if (!stable) begin fails++; $display("[TB] FAIL backpressure hold: got result %h in_ready %b expected 2a and 0", result, in_ready); end
      @(negedge clk);
      in_valid = 1'b1; op = 3'b000; a = 32'd2; b = 32'd2;
      do_handshake();
      tests++; if (out_valid !== 1'b0) begin fails++; $display("[TB] FAIL handshake out_valid: got %b expected 0", out_valid); end
      tests++; if (in_ready !== 1'b1) begin fails++; $display("[TB] FAIL handshake in_ready: got %b expected 1", in_ready); end
      tests++; if (busy !== 1'b0) begin fails++; $display("[TB] FAIL handshake no accept: got busy %b expected 0", busy); end
      in_valid = 1'b0;
   endtask

   task automatic test_flush();
      bit rose;
      do_accept(3'b101, 32'd100, 32'd7);
      repeat (10) @(posedge clk);
      @(negedge clk);
      flush = 1'b1;
      @(posedge clk); #1;
      flush = 1'b0;
      tests++; if (in_ready !== 1'b1 || busy !== 1'b0) begin fails++; $display("[TB] FAIL flush idle: got in_ready %b busy %b expected 1 0", in_ready, busy); end
      rose = 1'b0;
      for (int i = 0; i < 40; i++) begin
         if (out_valid) rose = 1'b1;
         @(posedge clk); #1;
      end
      tests++; if (rose) begin fails++; $display("[TB] FAIL flush out_valid: got 1 expected 0"); end
      @(negedge clk);
      in_valid = 1'b1; flush = 1'b1; op = 3'b101; a = 32'd5; b = 32'd0;
      @(posedge clk); #1;
      in_valid = 1'b0; flush = 1'b0;
      tests++; if (busy !== 1'b0 || out_valid !== 1'b0) begin fails++; $display("[TB] FAIL flush over accept: got busy %b out_valid %b expected 0 0", busy, out_valid); end
   endtask

   task automatic test_async_reset();
      int cyc;
      bit busy_ok;
      do_accept(3'b101, 32'd100, 32'd7);
      repeat (10) @(posedge clk);
      #3;
      rst_n = 1'b0;
      #1;
      tests++; if (in_ready !== 1'b1 || out_valid !== 1'b0 || busy !== 1'b0 || result !== 32'h0) begin
         fails++; $display("[TB] FAIL async reset: got in_ready %b out_valid %b busy %b result %h expected 1 0 0 0", in_ready, out_valid, busy, result);
      end
      @(negedge clk);
      rst_n = 1'b1;
      do_accept(3'b000, 32'd3, 32'd4);
      wait_valid(cyc, busy_ok);
      tests++; if (result !== 32'd12 || cyc != MUL_CYC) begin fails++; $display("[TB] FAIL post reset mul: got %h after %0d expected %h after %0d", result, cyc, 32'd12, MUL_CYC); end
      do_handshake();
   endtask

   initial begin
      rst_n = 1'b0; in_valid = 1'b0; op = 3'b000; a = '0; b = '0;
      flush = 1'b0; out_ready = 1'b0;
      test_reset();
      test_mul();
      test_div();
      test_special();
      test_input_hold();
      test_backpressure();
      test_flush();
      test_async_reset();
      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
